// File: rtl/psx_input_decoder_pkg.sv
// Shared constants for the PSX input decoder: button bit positions inside
// button_state, idle (nothing pressed, sticks centred) vectors, and the
// state encoding used by the stick hysteresis comparators.
package psx_pkg;

    localparam int PSX_BTN_SELECT = 15;
    localparam int PSX_BTN_START  = 12;
    localparam int PSX_BTN_UP     = 11;
    localparam int PSX_BTN_DOWN   = 9;
    localparam int PSX_BTN_CIRCLE = 2;
    localparam int PSX_BTN_CROSS  = 1;

    // Position of button_state inside the 48-bit {button_state, stick_state} word.
    localparam int PSX_RAW_BTN_LSB = 32;

    localparam logic [7:0]  PSX_STICK_CENTRE = 8'h80;
    localparam logic [15:0] PSX_BTN_IDLE     = 16'hFFFF;
    localparam logic [31:0] PSX_STICK_IDLE   = {4{PSX_STICK_CENTRE}};
    localparam logic [47:0] PSX_RAW_IDLE     = {PSX_BTN_IDLE, PSX_STICK_IDLE};

    typedef enum logic {
        REL = 1'b0,
        ACT = 1'b1
    } hyst_state_t;

endpackage

// File: rtl/psx_input_decoder_if.sv
// Poller-side vectors in, game-control levels and pulses out.
// master: the side that drives the raw vectors and consumes the controls.
// slave : the decoder.
interface psx_input_decoder_if;
    logic [15:0] button_state;
    logic [31:0] stick_state;
    logic        jump_held;
    logic        duck_held;
    logic        start_held;
    logic        jump_press;
    logic        duck_press;
    logic        start_press;
    logic        snapshot_valid;

    modport master (
        output button_state, stick_state,
        input  jump_held, duck_held, start_held,
        input  jump_press, duck_press, start_press, snapshot_valid
    );

    modport slave (
        input  button_state, stick_state,
        output jump_held, duck_held, start_held,
        output jump_press, duck_press, start_press, snapshot_valid
    );
endinterface

// File: rtl/psx_input_decoder_hyst_cmp.sv
// One 8-bit hysteresis comparator for a stick axis. Only evaluates on the
// enable strobe (the snapshot accept cycle).
//   state | meaning
//   REL   | axis not deflected far enough, act = 0
//   ACT   | axis deflected past the on threshold, act = 1 until off threshold
// DIR_LOW = 1: activates when val < ON_TH, releases when val >= OFF_TH.
// DIR_LOW = 0: activates when val > ON_TH, releases when val <= OFF_TH.
module psx_hyst_cmp
    import psx_pkg::*;
#(
    parameter logic [7:0] ON_TH   = 8'h40,
    parameter logic [7:0] OFF_TH  = 8'h60,
    parameter bit         DIR_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] val,
    output logic       act
);
    hyst_state_t state;
    logic        on_hit;
    logic        off_hit;

    assign on_hit  = DIR_LOW ? (val < ON_TH)   : (val > ON_TH);
    assign off_hit = DIR_LOW ? (val >= OFF_TH) : (val <= OFF_TH);

    // Two-state hysteresis FSM with registered activity output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= REL;
            act   <= 1'b0;
        end else if (en) begin
            case (state)
                REL: if (on_hit) begin
                    state <= ACT;
                    act   <= 1'b1;
                end
                ACT: if (off_hit) begin
                    state <= REL;
                    act   <= 1'b0;
                end
                default: begin
                    state <= REL;
                    act   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/psx_input_decoder.sv
// PSX controller input decoder: stability filter on the poller vectors,
// snapshot register, stick hysteresis and jump/duck/start decode.
// Build option: PSX_STICK_EN compiles in the left-stick up/down detectors
// and includes stick_state in the stability compare; without it the stick
// port is ignored and stick_up = stick_dn = 0.
module psx_input_decoder
    import psx_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 256,
    parameter logic [7:0]  STICK_UP_ON   = 8'h40,
    parameter logic [7:0]  STICK_UP_OFF  = 8'h60,
    parameter logic [7:0]  STICK_DN_ON   = 8'hC0,
    parameter logic [7:0]  STICK_DN_OFF  = 8'hA0
) (
    input  logic               clk,
    input  logic               rst,
    psx_input_decoder_if.slave bus
);
    localparam logic [15:0] STAB_MAX  = 16'(STABLE_CYCLES);
    localparam logic [15:0] STAB_LAST = 16'(STABLE_CYCLES - 1);

    logic [47:0] raw;
    logic [47:0] raw_q;
    logic [47:0] snap;
    logic [15:0] snap_btn;
    logic [15:0] stab_cnt;
    logic        accept;
    logic        snap_new;
    logic        stick_up;
    logic        stick_dn;
    logic        jump_req;
    logic        duck_req;
    logic        start_req;
    logic        duck_win;
    logic        jump_held_q, duck_held_q, start_held_q;
    logic        jump_press_q, duck_press_q, start_press_q;
    logic        snap_valid_q;

`ifdef PSX_STICK_EN
    assign raw = {bus.button_state, bus.stick_state};
`else
    assign raw = {bus.button_state, PSX_STICK_IDLE};
`endif

    // raw_q has no reset on purpose: it keeps tracking the poller while rst
    // is high, so a level held through reset is counted from release.
    always_ff @(posedge clk) begin
        raw_q <= raw;
    end

    assign accept = (stab_cnt == STAB_LAST) && (raw == raw_q);

    // Stability counter and snapshot register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt <= '0;
            snap     <= PSX_RAW_IDLE;
            snap_new <= 1'b0;
        end else begin
            if (raw != raw_q) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 16'd1;
            end
            snap_new <= accept && (raw_q != snap);
            if (accept) begin
                snap <= raw_q;
            end
        end
    end

`ifdef PSX_STICK_EN
    // The detectors see the value being accepted so they switch together with snap.
    psx_hyst_cmp #(
        .ON_TH   (STICK_UP_ON),
        .OFF_TH  (STICK_UP_OFF),
        .DIR_LOW (1'b1)
    ) u_stick_up (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .val (raw_q[7:0]),
        .act (stick_up)
    );

    psx_hyst_cmp #(
        .ON_TH   (STICK_DN_ON),
        .OFF_TH  (STICK_DN_OFF),
        .DIR_LOW (1'b0)
    ) u_stick_dn (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .val (raw_q[7:0]),
        .act (stick_dn)
    );
`else
    assign stick_up = 1'b0;
    assign stick_dn = 1'b0;
`endif

    assign snap_btn  = snap[PSX_RAW_BTN_LSB +: 16];
    assign jump_req  = !snap_btn[PSX_BTN_CROSS]  || !snap_btn[PSX_BTN_UP]   || stick_up;
    assign duck_req  = !snap_btn[PSX_BTN_CIRCLE] || !snap_btn[PSX_BTN_DOWN] || stick_dn;
    assign start_req = !snap_btn[PSX_BTN_START];
    assign duck_win  = duck_req && !jump_req;

    // Registered levels, rising-edge pulses and snapshot strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jump_held_q   <= 1'b0;
            duck_held_q   <= 1'b0;
            start_held_q  <= 1'b0;
            jump_press_q  <= 1'b0;
            duck_press_q  <= 1'b0;
            start_press_q <= 1'b0;
            snap_valid_q  <= 1'b0;
        end else begin
            jump_held_q   <= jump_req;
            duck_held_q   <= duck_win;
            start_held_q  <= start_req;
            jump_press_q  <= jump_req  && !jump_held_q;
            duck_press_q  <= duck_win  && !duck_held_q;
            start_press_q <= start_req && !start_held_q;
            snap_valid_q  <= snap_new;
        end
    end

    assign bus.jump_held      = jump_held_q;
    assign bus.duck_held      = duck_held_q;
    assign bus.start_held     = start_held_q;
    assign bus.jump_press     = jump_press_q;
    assign bus.duck_press     = duck_press_q;
    assign bus.start_press    = start_press_q;
    assign bus.snapshot_valid = snap_valid_q;
endmodule

// File: tb/tb_psx_input_decoder.sv
// Testbench for psx_input_decoder: directed scenarios plus randomized
// hold/glitch/reset sequences, compared every cycle against a timestamp
// based reference model (a value is accepted STABLE_CYCLES edges after the
// edge where it was first sampled, or after reset release).
`timescale 1ns/1ps
module tb_psx_input_decoder;
    localparam int S = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    psx_input_decoder_if bus();

    psx_input_decoder #(
        .STABLE_CYCLES (S),
        .STICK_UP_ON   (8'h40),
        .STICK_UP_OFF  (8'h60),
        .STICK_DN_ON   (8'hC0),
        .STICK_DN_OFF  (8'hA0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #250 clk = ~clk;

    // reference model state
    int          m_edge = 0;
    int          m_last_chg = 0;
    logic [47:0] m_prev = 48'hFFFF_8080_8080;
    logic [47:0] m_snap = 48'hFFFF_8080_8080;
    bit          m_up, m_dn, m_pend;
    bit          e_jh, e_dh, e_sh, e_jp, e_dp, e_sp, e_sv;

    // observation counters for directed checks
    int jp_cnt, dp_cnt, sp_cnt, sv_cnt;
    int jp_last, dp_last, sp_last;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, m_edge);
    endtask

    function automatic logic [6:0] dut_vec();
        return {bus.jump_held, bus.duck_held, bus.start_held,
                bus.jump_press, bus.duck_press, bus.start_press, bus.snapshot_valid};
    endfunction

    function automatic logic [6:0] exp_vec();
        return {e_jh, e_dh, e_sh, e_jp, e_dp, e_sp, e_sv};
    endfunction

    function automatic logic [47:0] sample();
`ifdef PSX_STICK_EN
        return {bus.button_state, bus.stick_state};
`else
        return {bus.button_state, 32'h8080_8080};
`endif
    endfunction

    task automatic model_reset();
        m_snap = 48'hFFFF_8080_8080;
        m_up = 0; m_dn = 0; m_pend = 0;
        {e_jh, e_dh, e_sh, e_jp, e_dp, e_sp, e_sv} = '0;
    endtask

    task automatic model_edge();
        logic [47:0] v;
        logic [15:0] b;
        logic [7:0]  ly;
        bit jr, dr, sr, dw;
        m_edge++;
        v = sample();
        if (rst) begin
            model_reset();
            m_prev = v;
            m_last_chg = m_edge;
            return;
        end
        // outputs after this edge reflect the snapshot held before it
        b  = m_snap[47:32];
        jr = !b[1] || !b[11] || m_up;
        dr = !b[2] || !b[9]  || m_dn;
        sr = !b[12];
        dw = dr && !jr;
        e_jp = jr && !e_jh; e_jh = jr;
        e_dp = dw && !e_dh; e_dh = dw;
        e_sp = sr && !e_sh; e_sh = sr;
        e_sv = m_pend; m_pend = 0;
        if (v != m_prev) m_last_chg = m_edge;
        m_prev = v;
        if (m_edge == m_last_chg + S) begin
            m_pend = (v != m_snap);
            m_snap = v;
`ifdef PSX_STICK_EN
            ly = v[7:0];
            if (ly < 8'h40) m_up = 1; else if (ly >= 8'h60) m_up = 0;
            if (ly > 8'hC0) m_dn = 1; else if (ly <= 8'hA0) m_dn = 0;
`else
            ly = 8'h80;
            if (ly != 8'h80) m_up = 1;
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_val("outputs", 64'(dut_vec()), 64'(exp_vec()));
        if (bus.jump_press)     begin jp_cnt++; jp_last = m_edge; end
        if (bus.duck_press)     begin dp_cnt++; dp_last = m_edge; end
        if (bus.start_press)    begin sp_cnt++; sp_last = m_edge; end
        if (bus.snapshot_valid) sv_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_val("rst_async", 64'(dut_vec()), 64'(exp_vec()));
    endtask

    initial begin
        int t0, sv0, jp0, dp0, sp0;
        logic [7:0] ly_steps [4];
        bit         up_exp   [4];
        logic [7:0] ly_pick  [10];

        bus.button_state = 16'hFFFF;
        bus.stick_state  = 32'h8080_8080;
        run(5);
        rst = 1'b0;

        // idle
        run(1000);
        check_val("idle_sv", sv_cnt, 0);
        check_val("idle_out", 64'(dut_vec()), 0);

        // CROSS press and release
        jp0 = jp_cnt;
        bus.button_state = 16'hFFFD; t0 = m_edge;
        run(300);
        check_val("cross_held", bus.jump_held, 1);
        check_val("cross_pulses", jp_cnt - jp0, 1);
        check_val("cross_latency", jp_last - t0, 258);
        bus.button_state = 16'hFFFF;
        run(300);
        check_val("cross_rel_held", bus.jump_held, 0);
        check_val("cross_rel_pulses", jp_cnt - jp0, 1);

        // glitch rejection
        sv0 = sv_cnt; jp0 = jp_cnt;
        for (int i = 0; i < 25; i++) begin
            bus.button_state ^= 16'h0002;
            run(8);
        end
        bus.button_state = 16'hFFFF;
        run(300);
        check_val("glitch_sv", sv_cnt - sv0, 0);
        check_val("glitch_jp", jp_cnt - jp0, 0);

        // hysteresis on ly
        ly_steps = '{8'h80, 8'h3F, 8'h50, 8'h60};
`ifdef PSX_STICK_EN
        up_exp = '{0, 1, 1, 0};
`else
        up_exp = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            bus.stick_state = {24'h808080, ly_steps[i]};
            run(300);
            check_val($sformatf("hyst_jump_%0d", i), bus.jump_held, up_exp[i]);
        end

        // conflict: jump wins over duck
        dp0 = dp_cnt;
        bus.button_state = 16'hFFF9;
        run(300);
        check_val("conf_jump", bus.jump_held, 1);
        check_val("conf_duck", bus.duck_held, 0);
        bus.button_state = 16'hFFFB;
        run(300);
        check_val("conf_duck_rel", bus.duck_held, 1);
        check_val("conf_duck_pulses", dp_cnt - dp0, 1);
        bus.button_state = 16'hFFFF;
        run(300);

        // a change on the saturating cycle blocks the accept; one more cycle lets it in
        sv0 = sv_cnt;
        bus.button_state = 16'hFFDF; run(S);
        bus.button_state = 16'hFFFF; run(300);
        check_val("block_sv", sv_cnt - sv0, 0);
        bus.button_state = 16'hFFDF; run(S + 1);
        bus.button_state = 16'hFFFF; run(300);
        check_val("edge_accept_sv", sv_cnt - sv0, 2);

        // reset mid-window with START held low
        sp0 = sp_cnt;
        bus.button_state = 16'hEFFF;
        run(201);
        assert_reset();
        run(3);
        rst = 1'b0; t0 = m_edge;
        run(300);
        check_val("rst_start_pulses", sp_cnt - sp0, 1);
        check_val("rst_start_latency", sp_last - t0, 257);
        bus.button_state = 16'hFFFF;
        run(300);

        // randomized holds, glitches and resets
        ly_pick = '{8'h3F, 8'h40, 8'h5F, 8'h60, 8'h80, 8'hA0, 8'hA1, 8'hC0, 8'hC1, 8'h00};
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: bus.button_state = 16'hFFFF;
                1: bus.button_state = ~(16'h1 << $urandom_range(0, 15));
                2: bus.button_state = ~((16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15)));
                default: bus.button_state = 16'($urandom);
            endcase
            ly_pick[9] = 8'($urandom);
            bus.stick_state = {24'($urandom), ly_pick[$urandom_range(0, 9)]};
            if ($urandom_range(0, 15) == 0) begin
                assert_reset();
                run($urandom_range(1, 3));
                rst = 1'b0;
            end
            run($urandom_range(0, 3) == 0 ? $urandom_range(1, 40) : $urandom_range(250, 320));
        end
        run(300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/psx_input_decoder.md
# psx_input_decoder

Consumes the raw `button_state`/`stick_state` vectors from the PSX controller poller and turns them into clean, registered game-control signals for the T-Rex game logic. The poller updates its vectors bit by bit during each transfer. This block therefore accepts a new input snapshot only after it has held unchanged for a programmable window. It then maps buttons and the left stick to jump/duck/start levels, with one-cycle press pulses. It sits between `psx_console` and the game state machine.

## Interface
- `STABLE_CYCLES`, 256: consecutive unchanged cycles required before a snapshot is accepted (range 1..65535).
- `STICK_UP_ON`, 8'h40: `ly` strictly below this asserts stick-up.
- `STICK_UP_OFF`, 8'h60: `ly` at or above this releases stick-up.
- `STICK_DN_ON`, 8'hC0: `ly` strictly above this asserts stick-down.
- `STICK_DN_OFF`, 8'hA0: `ly` at or below this releases stick-down.
- `clk  input  1`: system clock, 2 MHz (500 ns), rising edge.
- `rst  input  1`: asynchronous, active-high reset.
- `button_state  input  16`: active-low buttons from the poller. Bit map: [15] SELECT, [12] START, [11] UP, [9] DOWN, [2] CIRCLE, [1] CROSS.
- `stick_state  input  32`: {rx, ry, lx, ly}, 8'h80 = centre.
- `jump_held  output  1`: jump request level.
- `duck_held  output  1`: duck request level.
- `start_held  output  1`: START level.
- `jump_press  output  1`: one-cycle pulse on rising `jump_held`.
- `duck_press  output  1`: one-cycle pulse on rising `duck_held`.
- `start_press  output  1`: one-cycle pulse on rising `start_held`.
- `snapshot_valid  output  1`: one-cycle pulse each time a new snapshot is accepted.

## Operation
- Raw input: `raw = {button_state, stick_state}` (48 bits). It is registered once as `raw_q`.
- Filter counter `stab_cnt` (16 bit):
  - If `raw != raw_q`: counter is set to 0.
  - Otherwise the counter increments, saturating at `STABLE_CYCLES`.
- Snapshot accept: when the counter reaches `STABLE_CYCLES - 1` and `raw == raw_q`:
  - `snap <= raw_q`.
  - `snapshot_valid` pulses, but only if `raw_q != snap`.
  - No re-accept while the counter stays saturated.
- `snap` reset value: 16'hFFFF buttons, 32'h80808080 sticks. All outputs reset to 0.
- Stick FSMs, evaluated only on the accept cycle, each with states `REL` / `ACT`:
  - Up FSM: REL→ACT when `ly < STICK_UP_ON`; ACT→REL when `ly >= STICK_UP_OFF`. Otherwise hold.
  - Down FSM: REL→ACT when `ly > STICK_DN_ON`; ACT→REL when `ly <= STICK_DN_OFF`. Otherwise hold.
  - Both FSMs reset to REL.
- Decode (buttons active-low in `snap`):
  - `jump_req = !CROSS | !UP | stick_up`.
  - `duck_req = !CIRCLE | !DOWN | stick_dn`.
  - `start_req = !START`.
- Conflict rule: jump has priority. `duck_held = duck_req & !jump_req`.
- Press pulses: each `*_press` is `held & !held_prev`, exactly one cycle. A level that stays high never re-pulses.
- All six buttons not listed above, and rx/ry/lx, are ignored.

## Timing
- Latency from the last raw change at edge N to `snap` update: edge N+`STABLE_CYCLES`+1.
- `*_held`, `*_press` and `snapshot_valid` are registered and appear one edge after `snap` updates.
- Any raw change during the window restarts the count. Bit-by-bit poller updates (every 8 cycles) can never be accepted mid-transfer when `STABLE_CYCLES` > 8.
- Reset asserted mid-window: counter, `snap`, FSMs and outputs return to reset values immediately. After release, counting restarts from 0.
- A raw change on the cycle the counter saturates blocks the accept.

## Configuration
- `PSX_STICK_EN` defined:
  - Stick FSMs are compiled in.
  - `stick_state` bits take part in the stability compare.
- `PSX_STICK_EN` undefined:
  - Stick FSMs are removed and `stick_up = stick_dn = 0`.
  - Only `button_state` (16 bits) is filtered.
  - The `stick_state` port remains but is unused.

## Structure
- Package `psx_pkg` holds:
  - Button bit-index constants (`PSX_BTN_START`, `PSX_BTN_CROSS`, …).
  - Stick centre 8'h80 and the idle vectors 16'hFFFF / 32'h80808080.
  - The `REL`/`ACT` state encoding.
- Sub-module `psx_hyst_cmp`: one 8-bit hysteresis comparator (on/off thresholds, direction parameter, enable = accept strobe). It is instantiated twice.

## Test plan
- Idle: after reset, hold idle inputs (16'hFFFF, 32'h80808080) for 1000 cycles → all outputs 0, no `snapshot_valid`.
- CROSS press: `button_state` = 16'hFFFD held → `jump_held` = 1 and `jump_press` pulses exactly once, 258 edges after the change. Release → `jump_held` = 0 with no pulse.
- Glitch rejection: toggle bit 1 every 8 cycles for 200 cycles, then restore 16'hFFFF → no output change, no `snapshot_valid`.
- Hysteresis: step `ly` 8'h80 → 3F → 50 → 60, each step held 300 cycles → stick-up 0→1→1→0; `jump_held` follows.
- Conflict: CROSS and CIRCLE both low (16'hFFF9) → `jump_held` = 1, `duck_held` = 0. Release CROSS → `duck_held` = 1 with a single `duck_press`.
- Reset mid-window: assert `rst` at count 200 with START low, release, keep START low → `start_press` fires 257 edges after release.
